uart_time_rx: RTL and testbench
===============================

Name: uart_time_rx

Overview:
- UART receiver and command parser for setting the clock over the serial line. It is the receive-side counterpart of the time-report transmitter.
- It receives 8N1 bytes on uart_rx and parses the ASCII set-time command "T" YY MM DD HH mm followed by CR or LF.
- On a well-formed, in-range command it presents binary date/time values and a one-cycle set_valid strobe to the clock counter chain.

Parameters:
- CLK_HZ, 50000000, system clock frequency in Hz.
- BAUD, 9600, serial bit rate. CLKS_PER_BIT = CLK_HZ/BAUD = 5208 by integer division.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- uart_rx  input  1  serial line, idle high, asynchronous to clk.
- set_valid  output  1  one-cycle pulse; the set_* outputs are valid and new.
- set_year  output  7  year 0-99, binary.
- set_month  output  7  month 1-12, binary.
- set_day  output  7  day 1-31, binary.
- set_hour  output  7  hour 0-23, binary.
- set_min  output  7  minute 0-59, binary.
- frame_err  output  1  one-cycle pulse when a stop bit is sampled low.
- cmd_err  output  1  one-cycle pulse when a command is malformed or out of range.

Behaviour:
- Reset (async, rst_n=0):
  - set_valid, frame_err and cmd_err = 0.
  - set_year=0, set_month=1, set_day=1, set_hour=0, set_min=0.
  - Both FSMs go to idle; all counters clear; the synchronizer is preset to 1.
  - Reset asserted mid-byte or mid-command discards the partial data with no error pulse.
- uart_rx passes through a 2-flop synchronizer. All references to rx below mean the synchronized value.
- RX FSM:
  - IDLE: when rx is low, go to START and clear the bit counter.
  - START: count CLKS_PER_BIT/2 clocks (2604), then sample. If rx=0, go to DATA. If rx=1, treat it as a glitch and return to IDLE with no error.
  - DATA: sample every CLKS_PER_BIT clocks, 8 samples, LSB first, into a shift register. After the 8th sample, go to STOP.
  - STOP: sample after CLKS_PER_BIT clocks.
    - rx=1: internal byte_valid pulses for one cycle with the byte, and the FSM returns to IDLE.
    - rx=0: frame_err pulses, no byte is delivered, and the FSM goes to BREAK.
  - BREAK: wait until rx=1, then go to IDLE.
- Parser FSM (advances only on byte_valid):
  - P_IDLE: 0x54 ('T') goes to P_DIG with the digit index at 0. Any other byte is ignored without error.
  - P_DIG: bytes 0x30-0x39 are stored as 4-bit digits in index order: Y10, Y1, M10, M1, D10, D1, H10, H1, m10, m1. After the 10th digit, go to P_END.
    - Any other byte pulses cmd_err and returns to P_IDLE.
    - Exception: if that byte is 'T', pulse cmd_err and restart P_DIG at index 0.
  - P_END: 0x0D or 0x0A triggers the range check. Any other byte pulses cmd_err and returns to P_IDLE.
  - frame_err while in P_DIG or P_END returns the parser to P_IDLE without a cmd_err pulse.
- Conversion: each field value = tens*10 + ones, computed in 7 bits. The maximum value 99 fits in 7 bits.
- Range check at terminator:
  - Accept if 1<=month<=12, 1<=day<=31, hour<=23, min<=59. Year is always valid.
  - No per-month day check; the clock chain clamps the day.
  - Pass: all five set_* registers update together, and set_valid pulses in the cycle after the terminator's byte_valid.
  - Fail: cmd_err pulses in that same cycle, and the set_* outputs hold their values.
  - Either way the parser returns to P_IDLE.
- Latency: set_valid is high exactly 1 clk after the terminator's stop-bit sample. The outputs hold until the next accepted command.
- set_valid and cmd_err are never high in the same cycle.

Test Plan:
- Reset: with rst_n=0, set_* = 0/1/1/0/0 and all strobes are 0. Assert rst_n=0 mid-byte → no strobe follows, and the next clean command is accepted.
- Send "T2406151230\r" at 5208 clk/bit → one set_valid pulse. set_year=24, set_month=6, set_day=15, set_hour=12, set_min=30.
- Send "T2413011200\n" (month 13) → cmd_err pulses once, set_valid stays 0, and the outputs keep their previous values. Repeat with hour 24 and with minute 60; each gives the same result.
- Send "T24A6..." → cmd_err on 'A'. Then send "xT9912312359\n" → set_year=99, month 12, day 31, hour 23, min 59; the leading 'x' is ignored.
- Drive a byte whose stop bit is 0 during the digit phase → frame_err pulses once. The parser drops the command: the remaining digits plus CR give no strobe. After the line returns high, a full valid command is accepted.
- Pull rx low for 1000 clks (< 2604) → no byte_valid and no strobes, then a correct reception. Also check the first byte after a baud error of ±2% (bit period 5104/5312) is received correctly.

Source files
------------

// File: rtl/uart_time_rx.sv
// 8N1 UART receiver plus parser for the ASCII set-time command "T" YYMMDDHHmm <CR|LF>.
// An accepted command updates the set_* fields together and pulses set_valid for one cycle.
module uart_time_rx #(
  parameter int CLK_HZ = 50000000,
  parameter int BAUD   = 9600
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       uart_rx,
  output logic       set_valid,
  output logic [6:0] set_year,
  output logic [6:0] set_month,
  output logic [6:0] set_day,
  output logic [6:0] set_hour,
  output logic [6:0] set_min,
  output logic       frame_err,
  output logic       cmd_err
);
  localparam int CPB  = CLK_HZ / BAUD;
  localparam int HALF = CPB / 2;
  localparam int CW   = $clog2(CPB);

  typedef enum logic [2:0] {R_IDLE, R_START, R_DATA, R_STOP, R_BREAK} rx_st_t;
  typedef enum logic [1:0] {P_IDLE, P_DIG, P_END} p_st_t;

  logic          rx_s1, rx_s2;
  rx_st_t        rx_st;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;
  logic          byte_valid;

  p_st_t          p_st;
  logic [3:0]     idx;
  logic [9:0][3:0] dig;

  // uart_rx is asynchronous to clk; preset high so reset does not look like a start bit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_s1 <= 1'b1;
      rx_s2 <= 1'b1;
    end else begin
      rx_s1 <= uart_rx;
      rx_s2 <= rx_s1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_st      <= R_IDLE;
      cnt        <= '0;
      bit_cnt    <= '0;
      shreg      <= '0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
      case (rx_st)
        R_IDLE: if (!rx_s2) begin
          rx_st   <= R_START;
          cnt     <= '0;
          bit_cnt <= '0;
        end
        R_START: if (cnt == CW'(HALF - 1)) begin
          cnt   <= '0;
          rx_st <= rx_s2 ? R_IDLE : R_DATA;
        end else cnt <= cnt + CW'(1);
        R_DATA: if (cnt == CW'(CPB - 1)) begin
          cnt     <= '0;
          shreg   <= {rx_s2, shreg[7:1]};
          bit_cnt <= bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) rx_st <= R_STOP;
        end else cnt <= cnt + CW'(1);
        R_STOP: if (cnt == CW'(CPB - 1)) begin
          cnt <= '0;
          if (rx_s2) begin
            byte_valid <= 1'b1;
            rx_st      <= R_IDLE;
          end else begin
            frame_err <= 1'b1;
            rx_st     <= R_BREAK;
          end
        end else cnt <= cnt + CW'(1);
        R_BREAK: if (rx_s2) rx_st <= R_IDLE;
        default: rx_st <= R_IDLE;
      endcase
    end
  end

  function automatic logic [6:0] dec2(input logic [3:0] tens, input logic [3:0] ones);
    return 7'(tens) * 7'd10 + 7'(ones);
  endfunction

  logic [6:0] f_y, f_mo, f_d, f_h, f_mi;
  logic       in_range, is_digit, is_term;

  assign f_y      = dec2(dig[0], dig[1]);
  assign f_mo     = dec2(dig[2], dig[3]);
  assign f_d      = dec2(dig[4], dig[5]);
  assign f_h      = dec2(dig[6], dig[7]);
  assign f_mi     = dec2(dig[8], dig[9]);
  // day is only bounded to 1..31 here; the clock chain clamps it per month
  assign in_range = (f_mo >= 7'd1) && (f_mo <= 7'd12) && (f_d >= 7'd1) && (f_d <= 7'd31) &&
                    (f_h <= 7'd23) && (f_mi <= 7'd59);
  assign is_digit = (shreg >= 8'h30) && (shreg <= 8'h39);
  assign is_term  = (shreg == 8'h0D) || (shreg == 8'h0A);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_st      <= P_IDLE;
      idx       <= '0;
      dig       <= '0;
      set_valid <= 1'b0;
      cmd_err   <= 1'b0;
      set_year  <= 7'd0;
      set_month <= 7'd1;
      set_day   <= 7'd1;
      set_hour  <= 7'd0;
      set_min   <= 7'd0;
    end else begin
      set_valid <= 1'b0;
      cmd_err   <= 1'b0;
      if (frame_err) begin
        p_st <= P_IDLE;
      end else if (byte_valid) begin
        case (p_st)
          P_IDLE: if (shreg == 8'h54) begin
            p_st <= P_DIG;
            idx  <= '0;
          end
          P_DIG: if (is_digit) begin
            dig[idx] <= shreg[3:0];
            idx      <= idx + 4'd1;
            if (idx == 4'd9) p_st <= P_END;
          end else begin
            cmd_err <= 1'b1;
            idx     <= '0;
            if (shreg != 8'h54) p_st <= P_IDLE;
          end
          P_END: begin
            p_st <= P_IDLE;
            if (is_term && in_range) begin
              set_valid <= 1'b1;
              set_year  <= f_y;
              set_month <= f_mo;
              set_day   <= f_d;
              set_hour  <= f_h;
              set_min   <= f_mi;
            end else begin
              cmd_err <= 1'b1;
            end
          end
          default: p_st <= P_IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_uart_time_rx.sv
// Randomized bench for uart_time_rx; a queue-based command model predicts strobes and fields.
module tb_uart_time_rx;
  localparam int CLK_HZ = 3200;
  localparam int BAUD   = 100;
  localparam int PER    = CLK_HZ / BAUD;  // 32 clocks per bit keeps the run short

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       uart_rx = 1'b1;
  logic       set_valid, frame_err, cmd_err;
  logic [6:0] set_year, set_month, set_day, set_hour, set_min;

  uart_time_rx #(.CLK_HZ(CLK_HZ), .BAUD(BAUD)) dut (
    .clk(clk), .rst_n(rst_n), .uart_rx(uart_rx),
    .set_valid(set_valid), .set_year(set_year), .set_month(set_month), .set_day(set_day),
    .set_hour(set_hour), .set_min(set_min), .frame_err(frame_err), .cmd_err(cmd_err)
  );

  always #5 clk = ~clk;

  int n_vec = 0, n_miss = 0;
  int n_valid = 0, n_cmd = 0, n_frame = 0, n_both = 0;
  int exp_valid = 0, exp_cmd = 0, exp_frame = 0;
  logic [34:0] e_f = {7'd0, 7'd1, 7'd1, 7'd0, 7'd0};
  logic [34:0] got;
  logic [7:0]  pend[$];

  assign got = {set_year, set_month, set_day, set_hour, set_min};

  always @(negedge clk) if (rst_n) begin
    if (set_valid) n_valid++;
    if (cmd_err) n_cmd++;
    if (frame_err) n_frame++;
    if (set_valid && cmd_err) n_both++;
  end

  // Model: collect "T" + up to 10 digits; the 12th byte decides accept or reject.
  function automatic void model_byte(input logic [7:0] b);
    int v[5];
    if (pend.size() == 0) begin
      if (b == 8'h54) pend.push_back(b);
    end else if (pend.size() < 11) begin
      if (b >= 8'h30 && b <= 8'h39) pend.push_back(b);
      else begin
        exp_cmd++;
        pend.delete();
        if (b == 8'h54) pend.push_back(b);
      end
    end else begin
      if (b == 8'h0D || b == 8'h0A) begin
        for (int k = 0; k < 5; k++)
          v[k] = (int'(pend[1+2*k]) - 48) * 10 + (int'(pend[2+2*k]) - 48);
        if (v[1] >= 1 && v[1] <= 12 && v[2] >= 1 && v[2] <= 31 && v[3] <= 23 && v[4] <= 59) begin
          exp_valid++;
          e_f = {7'(v[0]), 7'(v[1]), 7'(v[2]), 7'(v[3]), 7'(v[4])};
        end else exp_cmd++;
      end else exp_cmd++;
      pend.delete();
    end
  endfunction

  task automatic drive_bits(input logic v, input int cycles);
    uart_rx = v;
    repeat (cycles) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input int per, input logic stop);
    drive_bits(1'b0, per);
    for (int i = 0; i < 8; i++) drive_bits(b[i], per);
    drive_bits(stop, per);
    if (stop) model_byte(b);
    else begin
      exp_frame++;
      pend.delete();
      drive_bits(1'b1, per);
    end
    uart_rx = 1'b1;
  endtask

  task automatic send_str(input string s, input int per);
    for (int i = 0; i < s.len(); i++) send_byte(s[i], per, 1'b1);
  endtask

  task automatic send_cmd(input string s, input logic [7:0] term, input int per);
    send_str(s, per);
    send_byte(term, per, 1'b1);
    drive_bits(1'b1, 4);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    uart_rx = 1'b1;
    repeat (3) @(negedge clk);
    n_vec++;
    if (got !== {7'd0, 7'd1, 7'd1, 7'd0, 7'd0}) begin
      n_miss++; $display("FAIL reset_fields: got %h want %h", got, {7'd0, 7'd1, 7'd1, 7'd0, 7'd0});
    end
    n_vec++;
    if ({set_valid, frame_err, cmd_err} !== 3'b000) begin
      n_miss++; $display("FAIL reset_strobes: got %b want 000", {set_valid, frame_err, cmd_err});
    end
    rst_n = 1'b1;
    drive_bits(1'b1, PER);
    send_str("T24", PER);
    drive_bits(1'b0, PER);
    drive_bits(1'b1, PER);
    drive_bits(1'b0, PER / 2);
    rst_n = 1'b0;
    pend.delete();
    drive_bits(1'b1, 4);
    rst_n = 1'b1;
    drive_bits(1'b1, 2 * PER);
    n_vec++;
    if ({n_valid, n_cmd, n_frame} !== {exp_valid, exp_cmd, exp_frame} || exp_valid + exp_cmd + exp_frame != 0) begin
      n_miss++; $display("FAIL reset_midbyte: got v=%0d c=%0d f=%0d want 0 0 0", n_valid, n_cmd, n_frame);
    end
    send_cmd("T0102030405", 8'h0D, PER);
    n_vec++;
    if (got !== {7'd1, 7'd2, 7'd3, 7'd4, 7'd5} || n_valid != 1) begin
      n_miss++; $display("FAIL reset_recover: got %h v=%0d want %h v=1", got, n_valid, {7'd1, 7'd2, 7'd3, 7'd4, 7'd5});
    end
  endtask

  task automatic test_valid();
    int b0 = n_valid;
    send_cmd("T2406151230", 8'h0D, PER);
    n_vec++;
    if (n_valid - b0 != 1) begin
      n_miss++; $display("FAIL valid_count: got %0d pulses want 1", n_valid - b0);
    end
    n_vec++;
    if (got !== {7'd24, 7'd6, 7'd15, 7'd12, 7'd30} || got !== e_f) begin
      n_miss++; $display("FAIL valid_fields: got %h want %h", got, e_f);
    end
  endtask

  task automatic test_range();
    string cmds[3] = '{"T2413011200", "T2406152400", "T2406151260"};
    for (int i = 0; i < 3; i++) begin
      int v0 = n_valid, c0 = n_cmd;
      logic [34:0] keep = got;
      send_cmd(cmds[i], (i == 0) ? 8'h0A : 8'h0D, PER);
      n_vec++;
      if (n_cmd - c0 != 1 || exp_cmd != n_cmd) begin
        n_miss++; $display("FAIL range_cmd_err[%0d]: got %0d pulses want 1", i, n_cmd - c0);
      end
      n_vec++;
      if (n_valid != v0) begin
        n_miss++; $display("FAIL range_no_valid[%0d]: got %0d pulses want 0", i, n_valid - v0);
      end
      n_vec++;
      if (got !== keep || got !== e_f) begin
        n_miss++; $display("FAIL range_hold[%0d]: got %h want %h", i, got, keep);
      end
    end
  endtask

  task automatic test_bad_char();
    int c0 = n_cmd;
    send_str("T24A6", PER);
    n_vec++;
    if (n_cmd - c0 != 1) begin
      n_miss++; $display("FAIL bad_char: got %0d cmd_err want 1", n_cmd - c0);
    end
    send_cmd("xT9912312359", 8'h0A, PER);
    n_vec++;
    if (got !== {7'd99, 7'd12, 7'd31, 7'd23, 7'd59}) begin
      n_miss++; $display("FAIL max_fields: got %h want %h", got, {7'd99, 7'd12, 7'd31, 7'd23, 7'd59});
    end
    n_vec++;
    if ({n_valid, n_cmd} !== {exp_valid, exp_cmd}) begin
      n_miss++; $display("FAIL bad_char_counts: got v=%0d c=%0d want v=%0d c=%0d", n_valid, n_cmd, exp_valid, exp_cmd);
    end
  endtask

  task automatic test_frame();
    int v0 = n_valid, c0 = n_cmd, f0 = n_frame;
    send_str("T12", PER);
    send_byte(8'h33, PER, 1'b0);
    send_cmd("0615120", 8'h0D, PER);
    n_vec++;
    if (n_frame - f0 != 1) begin
      n_miss++; $display("FAIL frame_err: got %0d pulses want 1", n_frame - f0);
    end
    n_vec++;
    if (n_valid != v0 || n_cmd != c0) begin
      n_miss++; $display("FAIL frame_drop: got v+%0d c+%0d want 0 0", n_valid - v0, n_cmd - c0);
    end
    send_cmd("T0711220845", 8'h0D, PER);
    n_vec++;
    if (got !== {7'd7, 7'd11, 7'd22, 7'd8, 7'd45} || n_valid - v0 != 1) begin
      n_miss++; $display("FAIL frame_recover: got %h want %h", got, {7'd7, 7'd11, 7'd22, 7'd8, 7'd45});
    end
  endtask

  task automatic test_glitch();
    int v0 = n_valid, c0 = n_cmd, f0 = n_frame;
    drive_bits(1'b0, 10);
    drive_bits(1'b1, 2 * PER);
    n_vec++;
    if (n_valid != v0 || n_cmd != c0 || n_frame != f0) begin
      n_miss++; $display("FAIL glitch: got strobes v+%0d c+%0d f+%0d want none", n_valid - v0, n_cmd - c0, n_frame - f0);
    end
    send_cmd("T3001020304", 8'h0A, PER);
    n_vec++;
    if (got !== e_f || n_valid - v0 != 1) begin
      n_miss++; $display("FAIL glitch_recover: got %h want %h", got, e_f);
    end
  endtask

  task automatic test_baud();
    // one clock off a 32-clock bit is roughly a 3% rate error
    send_cmd("T4502281900", 8'h0D, PER - 1);
    n_vec++;
    if (got !== {7'd45, 7'd2, 7'd28, 7'd19, 7'd0}) begin
      n_miss++; $display("FAIL baud_fast: got %h want %h", got, {7'd45, 7'd2, 7'd28, 7'd19, 7'd0});
    end
    send_cmd("T4610090741", 8'h0A, PER + 1);
    n_vec++;
    if (got !== {7'd46, 7'd10, 7'd9, 7'd7, 7'd41}) begin
      n_miss++; $display("FAIL baud_slow: got %h want %h", got, {7'd46, 7'd10, 7'd9, 7'd7, 7'd41});
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 3; i++) begin
      string s;
      s = $sformatf("T%02d%02d%02d%02d%02d", $urandom_range(0, 99), $urandom_range(0, 13),
                    $urandom_range(0, 32), $urandom_range(0, 24), $urandom_range(0, 60));
      send_cmd(s, ($urandom_range(0, 1) != 0) ? 8'h0D : 8'h0A, $urandom_range(PER - 1, PER + 1));
      n_vec++;
      if ({n_valid, n_cmd, n_frame} !== {exp_valid, exp_cmd, exp_frame}) begin
        n_miss++; $display("FAIL random_counts[%0d] %s: got v=%0d c=%0d f=%0d want v=%0d c=%0d f=%0d",
                           i, s, n_valid, n_cmd, n_frame, exp_valid, exp_cmd, exp_frame);
      end
      n_vec++;
      if (got !== e_f) begin
        n_miss++; $display("FAIL random_fields[%0d] %s: got %h want %h", i, s, got, e_f);
      end
    end
  endtask

  task automatic test_back_to_back();
    int v0 = n_valid;
    send_cmd("T2512312358", 8'h0D, PER);
    send_cmd("T2601010000", 8'h0A, PER);
    n_vec++;
    if (n_valid - v0 != 2 || got !== {7'd26, 7'd1, 7'd1, 7'd0, 7'd0}) begin
      n_miss++; $display("FAIL back_to_back: got %0d pulses %h want 2 %h", n_valid - v0, got, {7'd26, 7'd1, 7'd1, 7'd0, 7'd0});
    end
    n_vec++;
    if (n_both != 0) begin
      n_miss++; $display("FAIL valid_and_cmd_err: got %0d overlapping cycles want 0", n_both);
    end
  endtask

  initial begin
    test_reset();
    test_valid();
    test_range();
    test_bad_char();
    test_frame();
    test_glitch();
    test_baud();
    test_random();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
